// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and the MEM stage.
// Data wins by default; a starvation counter forces IF through periodically.
module mem_port_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    input  logic          flush,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [3:0]    starve_cnt
);

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic [3:0]         cnt_q;
    logic [3:0]         cnt_d;
    logic               if_win;
    logic               load_vld;
    logic [MEM_LAT-1:0] vld_q;
    logic [MEM_LAT-1:0] own_q;
    logic [MEM_LAT-1:0] vld_live;
    logic               last_vld;
    logic               last_own;

    // IF only beats a competing data request once it has starved long enough
    always_comb begin
        if_win = if_req & (~d_req | (cnt_q == SMAX));
    end

    assign if_gnt = if_win;
    assign d_gnt  = d_req & ~if_win;
    assign mem_en = if_gnt | d_gnt;
    assign mem_we = d_gnt & d_we;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_addr = d_addr;
            if (d_we) begin
                mem_wdata = d_wdata;
            end
        end else if (if_gnt) begin
            mem_addr = if_addr;
        end
    end

    always_comb begin
        cnt_d = '0;
        if (if_req && !if_gnt) begin
            cnt_d = (cnt_q == SMAX) ? cnt_q : cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starve_cnt = cnt_q;

    // Return tracking: own=1 marks an IF entry; flush kills those in place
    always_comb begin
        load_vld = mem_en & ~mem_we & ~(if_gnt & flush);
        vld_live = flush ? (vld_q & ~own_q) : vld_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            own_q <= '0;
        end else begin
            vld_q[0] <= load_vld;
            own_q[0] <= if_gnt;
            for (int i = 1; i < MEM_LAT; i++) begin
                vld_q[i] <= vld_live[i-1];
                own_q[i] <= own_q[i-1];
            end
        end
    end

    assign last_vld = vld_q[MEM_LAT-1];
    assign last_own = own_q[MEM_LAT-1];

    // A flush in the delivery cycle still suppresses the IF response
    assign if_rvalid = last_vld & last_own & ~flush;
    assign d_rvalid  = last_vld & ~last_own;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT 1..3) on shared stimulus,
// behavioural memory, scoreboard queues for read responses.
module tb_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          flush;

    logic          if_gnt    [3];
    logic          if_rvalid [3];
    logic [DW-1:0] if_rdata  [3];
    logic          d_gnt     [3];
    logic          d_rvalid  [3];
    logic [DW-1:0] d_rdata   [3];
    logic          mem_en    [3];
    logic          mem_we    [3];
    logic [AW-1:0] mem_addr  [3];
    logic [DW-1:0] mem_wdata [3];
    logic [DW-1:0] mem_rdata [3];
    logic [3:0]    starve_cnt[3];

    logic [DW-1:0] mem [0:1023];

    typedef struct packed {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t if_q[$];
    exp_t d_q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int a);
        return 32'hA500_0000 ^ (a * 32'h0001_0203);
    endfunction

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            logic [DW-1:0] rq [0:g];

            mem_port_arbiter #(
                .AW(AW), .DW(DW), .MEM_LAT(g + 1), .STARVE_MAX(4)
            ) u_dut (
                .clk(clk), .rst(rst),
                .if_req(if_req), .if_addr(if_addr),
                .if_gnt(if_gnt[g]), .if_rvalid(if_rvalid[g]),
                .if_rdata(if_rdata[g]),
                .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
                .d_wdata(d_wdata), .d_gnt(d_gnt[g]),
                .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
                .flush(flush),
                .mem_en(mem_en[g]), .mem_we(mem_we[g]),
                .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
                .mem_rdata(mem_rdata[g]),
                .starve_cnt(starve_cnt[g])
            );

            always @(posedge clk) begin
                rq[0] <= mem[mem_addr[g]];
                for (int i = 1; i <= g; i++) rq[i] <= rq[i-1];
            end
            assign mem_rdata[g] = rq[g];
        end
    endgenerate

    always @(posedge clk) begin
        if (mem_en[0] && mem_we[0]) mem[mem_addr[0]] <= mem_wdata[0];
    end

    task automatic drive(input logic ir, input int ia, input logic dr,
                         input logic dw, input int da,
                         input logic [DW-1:0] wd, input logic fl);
        if_req  = ir;
        if_addr = AW'(ia);
        d_req   = dr;
        d_we    = dw;
        d_addr  = AW'(da);
        d_wdata = wd;
        flush   = fl;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, '0, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks += 4;
            if (starve_cnt[k] !== 4'd0) begin
                errors++;
                $display("FAIL reset_starve[%0d] got %0d exp 0", k, starve_cnt[k]);
            end
            if (if_rvalid[k] !== 1'b0 || d_rvalid[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_rvalid[%0d] got %b/%b exp 0/0", k, if_rvalid[k], d_rvalid[k]);
            end
            if (mem_en[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mem_en[%0d] got %b exp 0", k, mem_en[k]);
            end
            if (if_gnt[k] !== 1'b0 || d_gnt[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_gnt[%0d] got %b/%b exp 0/0", k, if_gnt[k], d_gnt[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_if_stream();
        if_q.delete();
        for (int c = 0; c < 6; c++) begin
            if (c < 4) drive(1, c, 0, 0, 0, '0, 0);
            else       drive(0, 0, 0, 0, 0, '0, 0);
            #1;
            checks++;
            if (if_gnt[0] !== (c < 4)) begin
                errors++;
                $display("FAIL stream_gnt c=%0d got %b exp %b", c, if_gnt[0], c < 4);
            end
            if (c < 4) begin
                checks++;
                if (mem_addr[0] !== AW'(c) || mem_we[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_addr c=%0d got %0d/%b exp %0d/0", c, mem_addr[0], mem_we[0], c);
                end
                if_q.push_back('{data: pat(c), due: c + 1});
            end
            checks++;
            if (if_rvalid[0]) begin
                if (if_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_unexp c=%0d got rvalid exp none", c);
                end else begin
                    e = if_q.pop_front();
                    if (e.due != c || if_rdata[0] !== e.data) begin
                        errors++;
                        $display("FAIL stream_rdata c=%0d got %h exp %h due %0d", c, if_rdata[0], e.data, e.due);
                    end
                end
            end else if (if_q.size() > 0 && if_q[0].due <= c) begin
                errors++;
                $display("FAIL stream_missing c=%0d got rvalid=0 exp %h", c, if_q[0].data);
                void'(if_q.pop_front());
            end else if (if_rdata[0] !== '0) begin
                errors++;
                $display("FAIL stream_rdata_idle c=%0d got %h exp 0", c, if_rdata[0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_store_load();
        d_q.delete();
        for (int c = 0; c < 4; c++) begin
            case (c)
                0:       drive(0, 0, 1, 1, 5, 32'hDEADBEEF, 0);
                1:       drive(0, 0, 1, 0, 5, 32'h1234_5678, 0);
                default: drive(0, 0, 0, 0, 0, '0, 0);
            endcase
            #1;
            if (c == 0) begin
                checks++;
                if (d_gnt[0] !== 1'b1 || mem_we[0] !== 1'b1 || mem_addr[0] !== AW'(5)
                    || mem_wdata[0] !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL store_strobe got gnt=%b we=%b a=%0d wd=%h exp 1 1 5 deadbeef",
                             d_gnt[0], mem_we[0], mem_addr[0], mem_wdata[0]);
                end
            end
            if (c == 1) begin
                checks++;
                if (mem_we[0] !== 1'b0 || mem_wdata[0] !== '0) begin
                    errors++;
                    $display("FAIL load_strobe got we=%b wd=%h exp 0 0", mem_we[0], mem_wdata[0]);
                end
                d_q.push_back('{data: 32'hDEADBEEF, due: c + 1});
            end
            checks++;
            if (d_rvalid[0]) begin
                if (d_q.size() == 0) begin
                    errors++;
                    $display("FAIL sl_unexp c=%0d got d_rvalid exp none", c);
                end else begin
                    e = d_q.pop_front();
                    if (e.due != c || d_rdata[0] !== e.data) begin
                        errors++;
                        $display("FAIL sl_rdata c=%0d got %h exp %h due %0d", c, d_rdata[0], e.data, e.due);
                    end
                end
            end else if (d_q.size() > 0 && d_q[0].due <= c) begin
                errors++;
                $display("FAIL sl_missing c=%0d got d_rvalid=0 exp %h", c, d_q[0].data);
                void'(d_q.pop_front());
            end else if (d_rdata[0] !== '0) begin
                errors++;
                $display("FAIL sl_rdata_idle c=%0d got %h exp 0", c, d_rdata[0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_starve();
        int  s;
        logic exp_if;
        s = 0;
        for (int c = 0; c < 12; c++) begin
            drive(1, 20, 1, 0, 30, '0, 0);
            #1;
            exp_if = (s == 4);
            checks += 2;
            if (if_gnt[0] !== exp_if || d_gnt[0] !== !exp_if) begin
                errors++;
                $display("FAIL starve_gnt c=%0d got if=%b d=%b exp if=%b", c, if_gnt[0], d_gnt[0], exp_if);
            end
            if (starve_cnt[0] !== 4'(s) || mem_addr[0] !== AW'(exp_if ? 20 : 30)) begin
                errors++;
                $display("FAIL starve_cnt c=%0d got %0d a=%0d exp %0d a=%0d",
                         c, starve_cnt[0], mem_addr[0], s, exp_if ? 20 : 30);
            end
            s = exp_if ? 0 : ((s < 4) ? s + 1 : 4);
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0, '0, 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_flush();
        logic ir, dr, fl;
        int   ia;
        if_q.delete();
        d_q.delete();
        for (int c = 0; c < 15; c++) begin
            ir = 0; dr = 0; fl = 0; ia = 0;
            case (c)
                0:  begin ir = 1; ia = 8; end
                1:  begin ir = 1; ia = 9; end
                2:  begin ir = 1; ia = 11; fl = 1; end
                3:  dr = 1;
                4:  begin ir = 1; ia = 12; end
                8:  begin ir = 1; ia = 13; end
                11: fl = 1;
                default: ;
            endcase
            drive(ir, ia, dr, 0, 10, '0, fl);
            #1;
            if (fl) if_q.delete();
            if (ir || dr) begin
                checks++;
                if (if_gnt[2] !== ir || d_gnt[2] !== dr) begin
                    errors++;
                    $display("FAIL flush_gnt c=%0d got %b/%b exp %b/%b", c, if_gnt[2], d_gnt[2], ir, dr);
                end
            end
            if (ir && !fl) if_q.push_back('{data: pat(ia), due: c + 3});
            if (dr) d_q.push_back('{data: pat(10), due: c + 3});
            checks += 2;
            if (if_rvalid[2]) begin
                if (if_q.size() == 0) begin
                    errors++;
                    $display("FAIL flush_if_unexp c=%0d got if_rvalid data %h exp none", c, if_rdata[2]);
                end else begin
                    e = if_q.pop_front();
                    if (e.due != c || if_rdata[2] !== e.data) begin
                        errors++;
                        $display("FAIL flush_if_rdata c=%0d got %h exp %h due %0d", c, if_rdata[2], e.data, e.due);
                    end
                end
            end else if (if_q.size() > 0 && if_q[0].due <= c) begin
                errors++;
                $display("FAIL flush_if_missing c=%0d got 0 exp %h", c, if_q[0].data);
                void'(if_q.pop_front());
            end
            if (d_rvalid[2]) begin
                if (d_q.size() == 0) begin
                    errors++;
                    $display("FAIL flush_d_unexp c=%0d got d_rvalid exp none", c);
                end else begin
                    e = d_q.pop_front();
                    if (e.due != c || d_rdata[2] !== e.data) begin
                        errors++;
                        $display("FAIL flush_d_rdata c=%0d got %h exp %h due %0d", c, d_rdata[2], e.data, e.due);
                    end
                end
            end else if (d_q.size() > 0 && d_q[0].due <= c) begin
                errors++;
                $display("FAIL flush_d_missing c=%0d got 0 exp %h", c, d_q[0].data);
                void'(d_q.pop_front());
            end
            @(negedge clk);
        end
        checks++;
        if (if_q.size() != 0 || d_q.size() != 0) begin
            errors++;
            $display("FAIL flush_drain got %0d/%0d pending exp 0/0", if_q.size(), d_q.size());
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: drive(1, 3, 1, 0, 4, '0, 0);
                1: begin rst = 1'b1; drive(1, 3, 0, 0, 0, '0, 0); end
                default: begin rst = 1'b0; drive(0, 0, 0, 0, 0, '0, 0); end
            endcase
            #1;
            case (c)
                0: begin
                    checks++;
                    if (d_gnt[1] !== 1'b1 || if_gnt[1] !== 1'b0) begin
                        errors++;
                        $display("FAIL rmid_gnt got d=%b if=%b exp 1/0", d_gnt[1], if_gnt[1]);
                    end
                end
                1: begin
                    checks++;
                    if (starve_cnt[1] !== 4'd1 || if_gnt[1] !== 1'b1) begin
                        errors++;
                        $display("FAIL rmid_pre got cnt=%0d gnt=%b exp 1/1", starve_cnt[1], if_gnt[1]);
                    end
                end
                default: begin
                    checks += 2;
                    if (if_rvalid[1] !== 1'b0 || d_rvalid[1] !== 1'b0) begin
                        errors++;
                        $display("FAIL rmid_rvalid c=%0d got %b/%b exp 0/0", c, if_rvalid[1], d_rvalid[1]);
                    end
                    if (starve_cnt[1] !== 4'd0) begin
                        errors++;
                        $display("FAIL rmid_starve c=%0d got %0d exp 0", c, starve_cnt[1]);
                    end
                end
            endcase
            @(negedge clk);
        end
    endtask

    task automatic test_idle();
        drive(0, 0, 0, 0, 0, '0, 0);
        for (int c = 0; c < 4; c++) begin
            #1;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (mem_en[k] !== 1'b0 || if_gnt[k] !== 1'b0 || d_gnt[k] !== 1'b0
                    || starve_cnt[k] !== 4'd0 || mem_wdata[k] !== '0) begin
                    errors++;
                    $display("FAIL idle[%0d] c=%0d got en=%b g=%b%b cnt=%0d wd=%h exp all 0",
                             k, c, mem_en[k], if_gnt[k], d_gnt[k], starve_cnt[k], mem_wdata[k]);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = pat(i);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, '0, 0);
        @(negedge clk);
        test_reset();
        test_if_stream();
        test_store_load();
        test_starve();
        test_flush();
        test_reset_mid();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout got no finish exp finish");
        $fatal(1);
    end

endmodule
